rv32i_button_conditioner: RTL and testbench
===========================================

// Module: rv32i_button_conditioner
// PURPOSE
//   Conditions raw board push-buttons before the CPU samples them through the debug MMIO port (E0010000, LW).
//   Per button: 2-FF synchroniser, polarity fix, counter-based debouncer, press/release edge detect and sticky press flag.
//   btn_stable drives the debug block's 32-bit button input directly. btn_event/evt_clr give software latched presses.
// PARAMETERS
//   N_BTN        4      number of buttons, 1..32
//   DEBOUNCE     50000  cycles a synchronised level must hold before acceptance, >=2 (sim uses 4)
//   ACTIVE_LOW   1      1: raw pin low = pressed; 0: raw pin high = pressed
//   CNT_W        $clog2(DEBOUNCE+1)  counter width, derived, not overridden
// PORTS
//   clk         in   1       system clock
//   rst         in   1       asynchronous, active-high reset
//   btn_raw     in   N_BTN   asynchronous button pins
//   evt_clr     in   N_BTN   per-bit clear of btn_event, level, sampled each clk
//   btn_stable  out  32      debounced levels, 1 = pressed, bits [31:N_BTN] tied 0
//   btn_press   out  N_BTN   one-cycle pulse on accepted 0->1 of btn_stable
//   btn_release out  N_BTN   one-cycle pulse on accepted 1->0 of btn_stable
//   btn_event   out  32      sticky press flags, bits [31:N_BTN] tied 0
// BEHAVIOUR
//   Reset (async, rst=1): sync FFs at the released pin level, so the post-polarity value is 0.
//     Counters 0. btn_stable, btn_press, btn_release, btn_event all 0. Outputs hold 0 while rst=1.
//   Sync: s1<=btn_raw, s2<=s1. lvl = ACTIVE_LOW ? ~s2 : s2. No combinational path from btn_raw to any output.
//   Debounce, per bit i, on each posedge clk:
//     lvl==stable            -> cnt<=0.
//     lvl!=stable, cnt<DEBOUNCE-1 -> cnt<=cnt+1.
//     lvl!=stable, cnt==DEBOUNCE-1 -> stable<=lvl, cnt<=0.
//     Any edge where lvl==stable restarts the count; a bounce shorter than DEBOUNCE cycles is never accepted.
//   Latency: raw change set up before edge 1 and held steady -> btn_stable changes at edge DEBOUNCE+2.
//   Edges: btn_press[i]/btn_release[i] are registered on the same edge that updates stable[i].
//     Each is high exactly 1 cycle. Press and release of one bit are mutually exclusive.
//   Sticky flags, per bit: set on the btn_press pulse; evt_clr[i]=1 clears.
//     Set and clear in the same cycle -> set wins (no lost press). An already-set flag with no clear holds.
//   Bits are fully independent; simultaneous activity on several buttons needs no arbitration.
//   Reset mid-count: counter and stable return to 0 immediately. No pulse is emitted for the aborted transition.
//     After release, a held button re-qualifies after the full DEBOUNCE+2 cycles.
//   Width: counter never exceeds DEBOUNCE-1 and never wraps.
// TESTING (DEBOUNCE=4, N_BTN=4, ACTIVE_LOW=1)
//   1 Reset: assert rst mid-cycle with btn_raw=4'hF -> all outputs 0 asynchronously.
//       Release rst -> btn_stable stays 0.
//   2 Clean press: btn_raw[0] 1->0 before edge 1, held -> btn_stable=32'h1 at edge 6.
//       btn_press=4'h1 for exactly that cycle; btn_event=32'h1 thereafter.
//   3 Bounce reject: btn_raw[1] low 3 cycles, high 1, low 3, high -> btn_stable[1] never rises.
//       No press pulse.
//   4 Release: after test 2, btn_raw[0]->1 held -> btn_stable[0]=0 at edge 6 after the change.
//       btn_release=4'h1 for 1 cycle; btn_event[0] stays 1.
//   5 Clear race: evt_clr[2]=1 held while btn_press[2] pulses -> btn_event[2]=1 (set wins).
//       evt_clr[2]=1 on a later cycle alone -> btn_event[2]=0 on the next edge.
//   6 Reset mid-count: btn_raw[3] low 2 cycles post-sync, then rst pulse, raw still low -> no pulse during reset.
//       btn_stable[3]=1 exactly 6 edges after rst deasserts.

Source files
------------

// File: rtl/rv32i_button_conditioner.sv
// Push-button conditioner: per-bit 2-FF synchroniser, polarity fix, counter debouncer,
// press/release pulses and sticky press flags for software polling.
module rv32i_button_conditioner #(
  parameter int unsigned N_BTN      = 4,
  parameter int unsigned DEBOUNCE   = 50000,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  btn_raw,
  input  logic [N_BTN-1:0]  evt_clr,
  output logic [31:0]       btn_stable,
  output logic [N_BTN-1:0]  btn_press,
  output logic [N_BTN-1:0]  btn_release,
  output logic [31:0]       btn_event
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE - 1);
  // Synchroniser resets to the released pin level so the post-polarity level is 0.
  localparam logic [N_BTN-1:0] SyncRst = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] lvl;
  logic [N_BTN-1:0] stable_q, stable_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] event_q, event_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];

  always_comb begin
    lvl       = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (lvl[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i]  = lvl[i];
          press_d[i]   = lvl[i];
          release_d[i] = ~lvl[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    // A press pulse in the same cycle as a clear wins, so no press is lost.
    event_d = (event_q & ~evt_clr) | press_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= SyncRst;
      sync2_q   <= SyncRst;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      event_q   <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      event_q   <= event_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    btn_stable             = '0;
    btn_stable[N_BTN-1:0]  = stable_q;
    btn_event              = '0;
    btn_event[N_BTN-1:0]   = event_q;
  end

  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_rv32i_button_conditioner.sv
// Directed bench for rv32i_button_conditioner with DEBOUNCE=4, N_BTN=4, active-low pins.
module tb_rv32i_button_conditioner;

  logic        clk;
  logic        rst;
  logic [3:0]  btn_raw;
  logic [3:0]  evt_clr;
  logic [31:0] btn_stable;
  logic [3:0]  btn_press;
  logic [3:0]  btn_release;
  logic [31:0] btn_event;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  raw;
    logic [3:0]  clr;
    logic [31:0] stable;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic [31:0] evt;
  } vec_t;

  vec_t vecs[$];

  rv32i_button_conditioner #(
    .N_BTN     (4),
    .DEBOUNCE  (4),
    .ACTIVE_LOW(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .evt_clr    (evt_clr),
    .btn_stable (btn_stable),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_event  (btn_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] raw, input logic [3:0] clr, input logic [31:0] st,
                     input logic [3:0] pr, input logic [3:0] rl, input logic [31:0] ev);
    vec_t v;
    v.raw = raw; v.clr = clr; v.stable = st; v.press = pr; v.rel = rl; v.evt = ev;
    vecs.push_back(v);
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".stable"},  btn_stable, 32'h0);
    check({name, ".press"},   {28'h0, btn_press}, 32'h0);
    check({name, ".release"}, {28'h0, btn_release}, 32'h0);
    check({name, ".event"},   btn_event, 32'h0);
  endtask

  initial begin
    rst     = 1'b0;
    btn_raw = 4'hF;
    evt_clr = 4'h0;

    // Clean press of btn0: accepted at row 6, event latched one cycle after the pulse.
    for (int i = 1; i <= 5; i++) add(4'hE, 4'h0, 32'h0, 4'h0, 4'h0, 32'h0);
    add(4'hE, 4'h0, 32'h1, 4'h1, 4'h0, 32'h0);
    add(4'hE, 4'h0, 32'h1, 4'h0, 4'h0, 32'h1);
    add(4'hE, 4'h0, 32'h1, 4'h0, 4'h0, 32'h1);
    // Release of btn0: stable drops six edges after the pin change, event stays.
    for (int i = 9; i <= 13; i++) add(4'hF, 4'h0, 32'h1, 4'h0, 4'h0, 32'h1);
    add(4'hF, 4'h0, 32'h0, 4'h0, 4'h1, 32'h1);
    add(4'hF, 4'h0, 32'h0, 4'h0, 4'h0, 32'h1);
    // Bounce on btn1: low 3, high 1, low 3, then high; never accepted.
    for (int i = 0; i < 3; i++) add(4'hD, 4'h0, 32'h0, 4'h0, 4'h0, 32'h1);
    add(4'hF, 4'h0, 32'h0, 4'h0, 4'h0, 32'h1);
    for (int i = 0; i < 3; i++) add(4'hD, 4'h0, 32'h0, 4'h0, 4'h0, 32'h1);
    for (int i = 0; i < 6; i++) add(4'hF, 4'h0, 32'h0, 4'h0, 4'h0, 32'h1);

    // Reset: asynchronous clear, outputs stay 0 after release.
    #2 rst = 1'b1;
    #1 check_all_zero("reset_async");
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    check_all_zero("reset_release");

    for (int i = 0; i < vecs.size(); i++) begin
      btn_raw = vecs[i].raw;
      evt_clr = vecs[i].clr;
      step();
      check($sformatf("vec%0d.stable", i + 1), btn_stable, vecs[i].stable);
      check($sformatf("vec%0d.press", i + 1), {28'h0, btn_press}, {28'h0, vecs[i].press});
      check($sformatf("vec%0d.release", i + 1), {28'h0, btn_release}, {28'h0, vecs[i].rel});
      check($sformatf("vec%0d.event", i + 1), btn_event, vecs[i].evt);
    end

    // Clear race on btn2: clear held during the press pulse must not lose the press.
    btn_raw = 4'hB;
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("race_wait%0d.press", k), {28'h0, btn_press}, 32'h0);
    end
    step();
    check("race.stable", btn_stable, 32'h4);
    check("race.press", {28'h0, btn_press}, 32'h4);
    evt_clr = 4'h4;
    step();
    check("race.press_one_cycle", {28'h0, btn_press}, 32'h0);
    check("race.set_wins", btn_event, 32'h5);
    evt_clr = 4'h0;
    step();
    check("race.hold", btn_event, 32'h5);
    evt_clr = 4'h4;
    step();
    check("race.clear", btn_event, 32'h1);
    evt_clr = 4'h0;

    // Reset mid-count on btn3 (btn2 released at the same time, also mid-count).
    btn_raw = 4'h7;
    for (int k = 1; k <= 4; k++) step();
    check("midcnt.pre_stable", btn_stable, 32'h4);
    check("midcnt.pre_press", {28'h0, btn_press}, 32'h0);
    #3 rst = 1'b1;
    #1 check_all_zero("midcnt.async");
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk);
      #1 check_all_zero($sformatf("midcnt.in_reset%0d", k));
    end
    #3 rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("midcnt.post%0d.stable", k), btn_stable, 32'h0);
      check($sformatf("midcnt.post%0d.press", k), {28'h0, btn_press}, 32'h0);
    end
    step();
    check("midcnt.accept.stable", btn_stable, 32'h8);
    check("midcnt.accept.press", {28'h0, btn_press}, 32'h8);
    step();
    check("midcnt.after.press", {28'h0, btn_press}, 32'h0);
    check("midcnt.after.event", btn_event, 32'h8);

    // Final asynchronous reset with all pins released.
    btn_raw = 4'hF;
    #3 rst = 1'b1;
    #1 check_all_zero("final_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
